serializer_par: RTL

- Parametrised successor of the 16-bit serializer.
- Accepts a parallel word of DATA_W bits with a run-time length and shifts it out one bit per clock.
- Bit order is selectable: MSB-first or LSB-first.
- Adds an explicit last-bit marker and proper input-drop rules.
- Sits between a parallel data source and a single-wire serial link/deserializer.

---
 rtl/serializer_par_if.sv | 26 ++
 rtl/serializer_par.sv | 137 +++++++++++++
 2 files changed

// File: rtl/serializer_par_if.sv
// Parallel-to-serial link bundle for serializer_par.
// slave modport: serializer side (takes parallel words, drives the serial wire).
// master modport: parallel data source / serial consumer side.
interface serializer_par_if #(
  parameter int DATA_W = 16
);
  localparam int MW = $clog2(DATA_W);

  logic [DATA_W-1:0] data_i;
  logic [MW-1:0]     data_mod_i;
  logic              data_val_i;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_last_o;
  logic              busy_o;

  modport master (
    output data_i, data_mod_i, data_val_i,
    input  ser_data_o, ser_data_val_o, ser_last_o, busy_o
  );

  modport slave (
    input  data_i, data_mod_i, data_val_i,
    output ser_data_o, ser_data_val_o, ser_last_o, busy_o
  );
endinterface

// File: rtl/serializer_par.sv
// serializer_par: shifts a DATA_W-bit word out one bit per clock, with a
// run-time length (0 means DATA_W), selectable bit order and a last-bit
// marker. Requests shorter than MIN_LEN, or arriving mid-transfer, are dropped.
// Optional feature macro SERIALIZER_PARITY_EN: appends one even-parity bit
// after the data bits and moves ser_last_o onto it.
module serializer_par #(
  parameter int DATA_W    = 16,
  parameter int MIN_LEN   = 3,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  serializer_par_if.slave  bus
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW:0]   LEN_MAX = (CW+1)'(DATA_W);
  localparam logic [CW:0]   LEN_MIN = (CW+1)'(MIN_LEN);
  localparam logic [CW:0]   LEN_ONE = (CW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic              ser_data_q;
  logic              ser_val_q;
  logic              ser_last_q;
  logic              busy_q;
`ifdef SERIALIZER_PARITY_EN
  logic              par_q;
`endif

  logic [CW:0]       len_eff;
  logic [CW:0]       len_m1;
  logic              accept;
  logic              tx_bit;
  logic [DATA_W-1:0] shreg_d;

  // Request decode and the bit leaving the shift register this cycle.
  // Acceptance looks at the FSM rather than busy_o so that the next word can
  // be taken while the final bit is still on the wire (one idle gap only).
  always_comb begin
    len_eff = (bus.data_mod_i == '0) ? LEN_MAX : {1'b0, bus.data_mod_i};
    len_m1  = len_eff - LEN_ONE;
    accept  = bus.data_val_i && (state_q == IDLE) && (len_eff >= LEN_MIN);
    if (MSB_FIRST != 0) begin
      tx_bit  = shreg_q[DATA_W-1];
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
    end else begin
      tx_bit  = shreg_q[0];
      shreg_d = {1'b0, shreg_q[DATA_W-1:1]};
    end
  end

  // Transfer FSM with registered serial outputs; the counter holds the number
  // of data bits still to be presented after the current one.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      ser_last_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          ser_last_q <= 1'b0;
          busy_q     <= 1'b0;
          if (accept) begin
            shreg_q <= bus.data_i;
            cnt_q   <= len_m1[CW-1:0];
            state_q <= SEND;
`ifdef SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        SEND: begin
          ser_data_q <= tx_bit;
          ser_val_q  <= 1'b1;
          busy_q     <= 1'b1;
          shreg_q    <= shreg_d;
`ifdef SERIALIZER_PARITY_EN
          par_q      <= par_q ^ tx_bit;
`endif
          if (cnt_q == '0) begin
`ifdef SERIALIZER_PARITY_EN
            ser_last_q <= 1'b0;
            state_q    <= PARITY;
`else
            ser_last_q <= 1'b1;
            state_q    <= IDLE;
`endif
          end else begin
            ser_last_q <= 1'b0;
            cnt_q      <= cnt_q - CNT_ONE;
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          ser_data_q <= par_q;
          ser_val_q  <= 1'b1;
          ser_last_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= IDLE;
        end
`endif
        default: begin
          state_q    <= IDLE;
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          ser_last_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ser_data_o     = ser_data_q;
  assign bus.ser_data_val_o = ser_val_q;
  assign bus.ser_last_o     = ser_last_q;
  assign bus.busy_o         = busy_q;

endmodule
